// File: rtl/sys_defs.sv
// sys_defs: shared memory-interface types for the processor/memory boundary.
// Holds address/data/tag widths, command and size encodings, the owner
// enumeration used to route responses, and the owner-table entry layout.
package sys_defs;

  typedef logic [31:0] ADDR;
  typedef logic [63:0] DATA;
  typedef logic [3:0]  MEM_TAG;

  typedef enum logic [1:0] {
    MEM_NONE  = 2'h0,
    MEM_LOAD  = 2'h1,
    MEM_STORE = 2'h2
  } MEM_COMMAND;

  typedef enum logic [1:0] {
    BYTE   = 2'h0,
    HALF   = 2'h1,
    WORD   = 2'h2,
    DOUBLE = 2'h3
  } MEM_SIZE;

  typedef enum logic {
    ICACHE = 1'b0,
    DCACHE = 1'b1
  } MEM_OWNER;

  typedef struct packed {
    logic     valid;
    MEM_OWNER owner;
  } OWNER_ENTRY;

  // Tag 0 is reserved for "no transaction"; live tags are 1..NUM_TAGS-1.
  localparam int unsigned NUM_TAGS = 16;

endpackage

// File: rtl/mem_owner_table.sv
// mem_owner_table: records which requester owns each outstanding load tag.
// Ports:
//   clock, reset        rising-edge clock, asynchronous active-low clear
//   alloc_en/tag/owner  claim an entry at the next edge
//   lookup_tag          combinational lookup of a response tag
//   lookup_entry        entry for lookup_tag (all zero for tag 0)
//   retire_en           invalidate the looked-up entry at the next edge
module mem_owner_table
  import sys_defs::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       alloc_en,
  input  MEM_TAG     alloc_tag,
  input  MEM_OWNER   alloc_owner,
  input  MEM_TAG     lookup_tag,
  input  logic       retire_en,
  output OWNER_ENTRY lookup_entry
);

  // Entry 0 exists only to keep indexing simple; it is never written valid.
  OWNER_ENTRY table_q [NUM_TAGS];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NUM_TAGS; i++) begin
        table_q[i] <= '0;
      end
    end else begin
      if (retire_en && lookup_tag != '0) begin
        table_q[lookup_tag].valid <= 1'b0;
      end
      // Written after retire so a same-tag allocation in the same cycle wins.
      if (alloc_en && alloc_tag != '0) begin
        table_q[alloc_tag] <= '{valid: 1'b1, owner: alloc_owner};
      end
    end
  end

  assign lookup_entry = (lookup_tag == '0) ? '0 : table_q[lookup_tag];

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between the icache and the dcache/MSHR.
// The dcache wins contention unless the icache has lost STARVE_LIMIT cycles
// in a row. Accepted loads are recorded in mem_owner_table so the shared
// response bus can be steered back to the requester that issued them.
// Ports:
//   clock, reset                 rising-edge clock, async active-low reset
//   ic_req/ic_addr               icache load request
//   dc_req/dc_cmd/dc_addr/...    dcache load or store request
//   mem2proc_*                   memory accept tag, response tag and data
//   proc2mem_*                   command issued to memory this cycle
//   ic_gnt/dc_gnt, ic_tag/dc_tag acceptance and assigned tag
//   ic_resp_valid/dc_resp_valid  routed response strobe
//   resp_data/resp_tag           shared response payload
//   spurious_resp                response tag with no recorded owner
module mem_arbiter
  import sys_defs::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ic_req,
  input  ADDR        ic_addr,
  input  logic       dc_req,
  input  MEM_COMMAND dc_cmd,
  input  ADDR        dc_addr,
  input  DATA        dc_data,
  input  MEM_SIZE    dc_size,
  input  MEM_TAG     mem2proc_transaction_tag,
  input  MEM_TAG     mem2proc_data_tag,
  input  DATA        mem2proc_data,
  output MEM_COMMAND proc2mem_command,
  output ADDR        proc2mem_addr,
  output DATA        proc2mem_data,
  output MEM_SIZE    proc2mem_size,
  output logic       ic_gnt,
  output logic       dc_gnt,
  output MEM_TAG     ic_tag,
  output MEM_TAG     dc_tag,
  output logic       ic_resp_valid,
  output logic       dc_resp_valid,
  output DATA        resp_data,
  output MEM_TAG     resp_tag,
  output logic       spurious_resp
);

  localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 2);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

  logic [STARVE_W-1:0] starve_cnt;
  logic                ic_pend;
  logic                dc_pend;
  logic                ic_sel;
  logic                dc_sel;
  logic                accepted;
  logic                alloc_en;
  MEM_OWNER            alloc_owner;
  logic                resp_present;
  logic                resp_hit;
  OWNER_ENTRY          lookup_entry;

  // Requests are masked while reset is low so every output reads idle.
  assign ic_pend  = reset && ic_req;
  assign dc_pend  = reset && dc_req;
  assign ic_sel   = ic_pend && (!dc_pend || (starve_cnt >= STARVE_MAX));
  assign dc_sel   = dc_pend && !ic_sel;
  assign accepted = (mem2proc_transaction_tag != '0);

  always_comb begin
    proc2mem_command = MEM_NONE;
    proc2mem_addr    = '0;
    proc2mem_data    = '0;
    proc2mem_size    = BYTE;
    if (ic_sel) begin
      proc2mem_command = MEM_LOAD;
      proc2mem_addr    = ic_addr;
      proc2mem_size    = WORD;
    end else if (dc_sel) begin
      proc2mem_command = dc_cmd;
      proc2mem_addr    = dc_addr;
      proc2mem_data    = dc_data;
      proc2mem_size    = dc_size;
    end
  end

  assign ic_gnt = ic_sel && accepted;
  assign dc_gnt = dc_sel && accepted;
  assign ic_tag = ic_gnt ? mem2proc_transaction_tag : '0;
  assign dc_tag = dc_gnt ? mem2proc_transaction_tag : '0;

  // Only loads produce a response, so only they claim an owner entry.
  assign alloc_en    = ic_gnt || (dc_gnt && dc_cmd == MEM_LOAD);
  assign alloc_owner = ic_gnt ? ICACHE : DCACHE;

  assign resp_present  = reset && (mem2proc_data_tag != '0);
  assign resp_hit      = resp_present && lookup_entry.valid;
  assign ic_resp_valid = resp_hit && (lookup_entry.owner == ICACHE);
  assign dc_resp_valid = resp_hit && (lookup_entry.owner == DCACHE);
  assign spurious_resp = resp_present && !lookup_entry.valid;
  assign resp_data     = resp_present ? mem2proc_data : '0;
  assign resp_tag      = resp_present ? mem2proc_data_tag : '0;

  mem_owner_table u_owner_table (
    .clock        (clock),
    .reset        (reset),
    .alloc_en     (alloc_en),
    .alloc_tag    (mem2proc_transaction_tag),
    .alloc_owner  (alloc_owner),
    .lookup_tag   (mem2proc_data_tag),
    .retire_en    (resp_hit),
    .lookup_entry (lookup_entry)
  );

  // Counts consecutive cycles the icache waited without being accepted,
  // including cycles where it won arbitration but memory rejected it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      starve_cnt <= '0;
    end else if (ic_req && !ic_gnt) begin
      if (starve_cnt < STARVE_MAX) begin
        starve_cnt <= starve_cnt + STARVE_W'(1);
      end
    end else begin
      starve_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios with literal expectations, then random
// traffic, all checked every cycle against a behavioural model of arbitration,
// starvation and tag ownership.
module tb_mem_arbiter;
  import sys_defs::*;

  localparam int unsigned LIMIT = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       ic_req = 1'b0;
  ADDR        ic_addr = '0;
  logic       dc_req = 1'b0;
  MEM_COMMAND dc_cmd = MEM_LOAD;
  ADDR        dc_addr = '0;
  DATA        dc_data = '0;
  MEM_SIZE    dc_size = BYTE;
  MEM_TAG     mem2proc_transaction_tag = '0;
  MEM_TAG     mem2proc_data_tag = '0;
  DATA        mem2proc_data = '0;
  MEM_COMMAND proc2mem_command;
  ADDR        proc2mem_addr;
  DATA        proc2mem_data;
  MEM_SIZE    proc2mem_size;
  logic       ic_gnt, dc_gnt, ic_resp_valid, dc_resp_valid, spurious_resp;
  MEM_TAG     ic_tag, dc_tag, resp_tag;
  DATA        resp_data;

  mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clock                    (clock),
    .reset                    (reset),
    .ic_req                   (ic_req),
    .ic_addr                  (ic_addr),
    .dc_req                   (dc_req),
    .dc_cmd                   (dc_cmd),
    .dc_addr                  (dc_addr),
    .dc_data                  (dc_data),
    .dc_size                  (dc_size),
    .mem2proc_transaction_tag (mem2proc_transaction_tag),
    .mem2proc_data_tag        (mem2proc_data_tag),
    .mem2proc_data            (mem2proc_data),
    .proc2mem_command         (proc2mem_command),
    .proc2mem_addr            (proc2mem_addr),
    .proc2mem_data            (proc2mem_data),
    .proc2mem_size            (proc2mem_size),
    .ic_gnt                   (ic_gnt),
    .dc_gnt                   (dc_gnt),
    .ic_tag                   (ic_tag),
    .dc_tag                   (dc_tag),
    .ic_resp_valid            (ic_resp_valid),
    .dc_resp_valid            (dc_resp_valid),
    .resp_data                (resp_data),
    .resp_tag                 (resp_tag),
    .spurious_resp            (spurious_resp)
  );

  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: who owns each tag, and how long icache has waited.
  bit          m_valid [16];
  bit          m_is_dc [16];
  int unsigned m_starve = 0;

  logic [63:0] e_cmd, e_addr, e_data, e_size, e_ic_gnt, e_dc_gnt, e_ic_tag, e_dc_tag;
  logic [63:0] e_ic_rv, e_dc_rv, e_rdata, e_rtag, e_spur;
  bit          pick_ic, pick_dc, hit;
  int unsigned tt, dt;

  always @(negedge clock) begin
    e_cmd = 64'(MEM_NONE); e_addr = 0; e_data = 0; e_size = 64'(BYTE);
    e_ic_gnt = 0; e_dc_gnt = 0; e_ic_tag = 0; e_dc_tag = 0;
    e_ic_rv = 0; e_dc_rv = 0; e_rdata = 0; e_rtag = 0; e_spur = 0;
    tt = mem2proc_transaction_tag;
    dt = mem2proc_data_tag;
    hit = 1'b0;
    if (!reset) begin
      for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
      m_starve = 0;
    end else begin
      pick_ic = ic_req && (!dc_req || m_starve >= LIMIT);
      pick_dc = dc_req && !pick_ic;
      if (pick_ic) begin
        e_cmd = 64'(MEM_LOAD); e_addr = 64'(ic_addr); e_size = 64'(WORD);
      end else if (pick_dc) begin
        e_cmd = 64'(dc_cmd); e_addr = 64'(dc_addr); e_data = dc_data; e_size = 64'(dc_size);
      end
      if (tt != 0) begin
        e_ic_gnt = 64'(pick_ic); e_dc_gnt = 64'(pick_dc);
        if (pick_ic) e_ic_tag = 64'(tt);
        if (pick_dc) e_dc_tag = 64'(tt);
      end
      if (dt != 0) begin
        hit = m_valid[dt];
        e_rdata = mem2proc_data; e_rtag = 64'(dt);
        e_spur = 64'(!hit);
        e_ic_rv = 64'(hit && !m_is_dc[dt]);
        e_dc_rv = 64'(hit && m_is_dc[dt]);
      end
      // State for the coming edge: retire first, then allocation overrides.
      if (hit) m_valid[dt] = 1'b0;
      if (e_ic_gnt[0]) begin
        m_valid[tt] = 1'b1; m_is_dc[tt] = 1'b0;
      end else if (e_dc_gnt[0] && dc_cmd == MEM_LOAD) begin
        m_valid[tt] = 1'b1; m_is_dc[tt] = 1'b1;
      end
      if (ic_req && !e_ic_gnt[0]) m_starve = (m_starve < LIMIT) ? m_starve + 1 : LIMIT;
      else m_starve = 0;
    end
    check("cmd", 64'(proc2mem_command), e_cmd);
    check("addr", 64'(proc2mem_addr), e_addr);
    check("wdata", proc2mem_data, e_data);
    check("size", 64'(proc2mem_size), e_size);
    check("ic_gnt", 64'(ic_gnt), e_ic_gnt);
    check("dc_gnt", 64'(dc_gnt), e_dc_gnt);
    check("ic_tag", 64'(ic_tag), e_ic_tag);
    check("dc_tag", 64'(dc_tag), e_dc_tag);
    check("ic_resp_valid", 64'(ic_resp_valid), e_ic_rv);
    check("dc_resp_valid", 64'(dc_resp_valid), e_dc_rv);
    check("resp_data", resp_data, e_rdata);
    check("resp_tag", 64'(resp_tag), e_rtag);
    check("spurious", 64'(spurious_resp), e_spur);
  end

  task automatic drive(input logic ir, input ADDR ia, input logic dr, input MEM_COMMAND dcmd,
                       input ADDR da, input DATA dd, input MEM_SIZE ds,
                       input MEM_TAG ttag, input MEM_TAG dtag, input DATA md);
    ic_req = ir; ic_addr = ia; dc_req = dr; dc_cmd = dcmd; dc_addr = da;
    dc_data = dd; dc_size = ds; mem2proc_transaction_tag = ttag;
    mem2proc_data_tag = dtag; mem2proc_data = md;
  endtask

  task automatic idle(input MEM_TAG dtag, input DATA md);
    drive(1'b0, '0, 1'b0, MEM_LOAD, '0, '0, BYTE, '0, dtag, md);
  endtask

  initial begin
    idle('0, '0);
    repeat (2) @(posedge clock);
    #3;
    check("rst_cmd", 64'(proc2mem_command), 64'(MEM_NONE));
    check("rst_gnt", 64'({ic_gnt, dc_gnt, ic_resp_valid, dc_resp_valid, spurious_resp}), 64'd0);
    check("rst_bus", 64'(proc2mem_addr) | proc2mem_data | resp_data, 64'd0);
    @(posedge clock); #1 reset = 1'b1;

    // Contention: dcache wins and takes tag 3.
    @(posedge clock); #1;
    drive(1'b1, 32'h100, 1'b1, MEM_STORE, 32'h200, 64'h55, DOUBLE, 4'd3, '0, '0);
    #2;
    check("s1_dc_gnt", 64'(dc_gnt), 64'd1);
    check("s1_dc_tag", 64'(dc_tag), 64'd3);
    check("s1_ic_gnt", 64'(ic_gnt), 64'd0);
    check("s1_addr", 64'(proc2mem_addr), 64'h200);
    @(posedge clock); #1 idle('0, 64'hABCD);
    #2;
    check("idle_resp_data", resp_data, 64'd0);
    check("idle_resp_tag", 64'(resp_tag), 64'd0);

    // Starvation: dcache wins four times, icache the fifth.
    for (int k = 0; k < 5; k++) begin
      @(posedge clock); #1;
      drive(1'b1, 32'h104, 1'b1, MEM_STORE, 32'h208, 64'h66, WORD, MEM_TAG'(k + 1), '0, '0);
      #2;
      check("s2_ic_gnt", 64'(ic_gnt), (k == 4) ? 64'd1 : 64'd0);
      check("s2_dc_gnt", 64'(dc_gnt), (k == 4) ? 64'd0 : 64'd1);
    end
    check("s2_ic_tag", 64'(ic_tag), 64'd5);
    check("s2_ic_cmd", 64'(proc2mem_command), 64'(MEM_LOAD));
    check("s2_ic_size", 64'(proc2mem_size), 64'(WORD));
    check("s2_ic_data", proc2mem_data, 64'd0);
    @(posedge clock); #1;
    drive(1'b1, 32'h104, 1'b1, MEM_STORE, 32'h208, 64'h66, WORD, 4'd6, '0, '0);
    #2 check("s2_after_dc_gnt", 64'(dc_gnt), 64'd1);

    // Retire tag 5 (icache) while the dcache reallocates tag 5.
    @(posedge clock); #1;
    drive(1'b0, '0, 1'b1, MEM_LOAD, 32'h300, '0, WORD, 4'd5, 4'd5, 64'h1111);
    #2;
    check("s5_ic_rv", 64'(ic_resp_valid), 64'd1);
    check("s5_dc_rv", 64'(dc_resp_valid), 64'd0);
    check("s5_dc_tag", 64'(dc_tag), 64'd5);
    @(posedge clock); #1 idle(4'd5, 64'h2222);
    #2;
    check("s5_dc_rv2", 64'(dc_resp_valid), 64'd1);
    check("s5_ic_rv2", 64'(ic_resp_valid), 64'd0);

    // Icache load tag 7 and its response.
    @(posedge clock); #1;
    drive(1'b1, 32'h400, 1'b0, MEM_LOAD, '0, '0, BYTE, 4'd7, '0, '0);
    #2 check("s3_ic_tag", 64'(ic_tag), 64'd7);
    @(posedge clock); #1 idle(4'd7, 64'hDEAD);
    #2;
    check("s3_ic_rv", 64'(ic_resp_valid), 64'd1);
    check("s3_resp_data", resp_data, 64'hDEAD);
    check("s3_dc_rv", 64'(dc_resp_valid), 64'd0);

    // Store tag 2 owns nothing, so its response is spurious.
    @(posedge clock); #1;
    drive(1'b0, '0, 1'b1, MEM_STORE, 32'h500, 64'h77, HALF, 4'd2, '0, '0);
    #2 check("s4_dc_gnt", 64'(dc_gnt), 64'd1);
    @(posedge clock); #1 idle(4'd2, 64'h99);
    #2;
    check("s4_spur", 64'(spurious_resp), 64'd1);
    check("s4_rv", 64'({ic_resp_valid, dc_resp_valid}), 64'd0);

    // Memory rejects with tag 0: command driven, nothing granted.
    @(posedge clock); #1;
    drive(1'b1, 32'h600, 1'b1, MEM_STORE, 32'h604, 64'h1, BYTE, 4'd0, '0, '0);
    #2;
    check("rej_gnt", 64'({ic_gnt, dc_gnt}), 64'd0);
    check("rej_cmd", 64'(proc2mem_command), 64'(MEM_STORE));

    // Reset mid-operation drops outstanding tag 9.
    @(posedge clock); #1;
    drive(1'b1, 32'h700, 1'b0, MEM_LOAD, '0, '0, BYTE, 4'd9, '0, '0);
    #2 check("s6_ic_tag", 64'(ic_tag), 64'd9);
    @(posedge clock); #1;
    drive(1'b1, 32'h704, 1'b0, MEM_LOAD, '0, '0, BYTE, 4'd4, '0, '0);
    #1 reset = 1'b0;
    #1;
    check("s6_rst_cmd", 64'(proc2mem_command), 64'(MEM_NONE));
    check("s6_rst_gnt", 64'(ic_gnt), 64'd0);
    check("s6_rst_addr", 64'(proc2mem_addr), 64'd0);
    @(posedge clock); #1 idle('0, '0);
    #1 reset = 1'b1;
    @(posedge clock); #1 idle(4'd9, 64'h5);
    #2 check("s6_spur", 64'(spurious_resp), 64'd1);

    // Random traffic, with occasional resets.
    repeat (500) begin
      @(posedge clock); #1;
      reset = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
      drive($urandom_range(0, 1) == 1, $urandom, $urandom_range(0, 1) == 1,
            ($urandom_range(0, 1) == 1) ? MEM_LOAD : MEM_STORE, $urandom,
            {$urandom, $urandom}, MEM_SIZE'($urandom_range(0, 3)),
            ($urandom_range(0, 3) == 0) ? 4'd0 : MEM_TAG'($urandom_range(1, 15)),
            ($urandom_range(0, 1) == 0) ? 4'd0 : MEM_TAG'($urandom_range(1, 15)),
            {$urandom, $urandom});
    end
    @(posedge clock); #1 reset = 1'b1; idle('0, '0);
    repeat (2) @(posedge clock);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, meaning consecutive lost-arbitration cycles after which the icache requester wins.
REQ-002 SHALL have ports (name  direction  width  meaning):
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- ic_req  in  1  icache load request; held until granted
- ic_addr  in  ADDR  icache load address
- dc_req  in  1  dcache/MSHR request; held until granted
- dc_cmd  in  MEM_COMMAND  MEM_LOAD or MEM_STORE
- dc_addr  in  ADDR  dcache address
- dc_data  in  DATA  store data
- dc_size  in  MEM_SIZE  store size
- mem2proc_transaction_tag  in  MEM_TAG  nonzero when the issued command is accepted
- mem2proc_data_tag  in  MEM_TAG  nonzero when response data is valid
- mem2proc_data  in  DATA  response data
- proc2mem_command  out  MEM_COMMAND  command to memory
- proc2mem_addr  out  ADDR  address to memory
- proc2mem_data  out  DATA  store data to memory
- proc2mem_size  out  MEM_SIZE  size to memory
- ic_gnt, dc_gnt  out  1 each  request accepted this cycle
- ic_tag, dc_tag  out  MEM_TAG each  transaction tag of accepted request
- ic_resp_valid, dc_resp_valid  out  1 each  response for that requester this cycle
- resp_data  out  DATA  shared response data
- resp_tag  out  MEM_TAG  shared response tag
- spurious_resp  out  1  response tag had no owner

Function
REQ-003 SHALL issue at most one command per cycle; proc2mem_command = MEM_NONE when neither request is pending.
REQ-004 SHALL select dcache when both request, unless starve_cnt >= STARVE_LIMIT, in which case icache is selected.
REQ-005 SHALL drive the winner's command, address, data and size combinationally in the same cycle; icache always issues MEM_LOAD with size WORD and data 0.
REQ-006 SHALL assert the winner's gnt and tag combinationally only when mem2proc_transaction_tag != 0; tag 0 means rejection, no gnt, and the requester retries next cycle.
REQ-007 SHALL increment starve_cnt (saturating at STARVE_LIMIT) on each cycle ic_req is high without ic_gnt, and clear it on ic_gnt or when ic_req is low.
REQ-008 SHALL keep a 15-entry owner table indexed by tag 1..15 (valid bit plus owner bit); an accepted MEM_LOAD sets the entry at the following edge; accepted stores set no entry.
REQ-009 SHALL, when mem2proc_data_tag != 0 and that entry is valid, pulse the owner's resp_valid combinationally, drive resp_data/resp_tag from memory, and clear the entry at the next edge.
REQ-010 SHALL, when mem2proc_data_tag != 0 and the entry is invalid, pulse spurious_resp, assert no resp_valid, and leave the table unchanged.
REQ-011 SHALL, when one cycle both retires and allocates the same tag, let allocation win (entry ends valid with the new owner).
REQ-012 SHALL route a response for tag T and accept a new request in the same cycle independently.
REQ-013 SHALL hold resp_data/resp_tag at 0 when mem2proc_data_tag == 0.

Reset
REQ-014 SHALL, while reset is low, asynchronously clear all owner-table entries and starve_cnt.
REQ-015 SHALL, during and after reset until requests arrive, output MEM_NONE, all gnt/resp_valid/spurious_resp 0, and all tags, addresses and data 0.
REQ-016 SHALL discard in-flight ownership on reset mid-operation; later responses carrying those tags raise spurious_resp.

Structure
REQ-017 SHALL place ADDR, DATA, MEM_TAG, MEM_COMMAND and MEM_SIZE in sys_defs, plus new typedef MEM_OWNER (ICACHE, DCACHE) and the owner-table entry struct.
REQ-018 SHALL contain one sub-module, mem_owner_table (allocate port, lookup/retire port, async clear); arbitration logic stays in the parent.

Verification
REQ-019 Directed scenarios:
- Both request, trans tag 3 -> dc_gnt=1, dc_tag=3, ic_gnt=0; starve_cnt=1.
- Both request continuously with tags 1..5 -> dc wins cycles 0-3, ic wins cycle 4 (STARVE_LIMIT=4), then starve_cnt=0.
- ic load accepted tag 7, then data_tag 7, data 0xDEAD -> ic_resp_valid=1, resp_data=0xDEAD, dc_resp_valid=0.
- dc store accepted tag 2, then data_tag 2 -> spurious_resp=1, no resp_valid.
- Retire tag 5 (ic) and dc load accepted as tag 5 in the same cycle -> ic_resp_valid=1; next data_tag 5 -> dc_resp_valid=1.
- Load tag 9 outstanding, reset pulled low mid-cycle -> outputs 0 immediately; data_tag 9 after release -> spurious_resp=1.
